// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter shared by the instruction cache (word fetches) and
// the load/store buffer. It serves one transaction at a time and splits it into byte accesses.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        IC_req,
    input  logic [31:0] IC_addr,
    output logic        IC_done,
    output logic [31:0] IC_data,
    input  logic        LS_req,
    input  logic        LS_wr,
    input  logic [31:0] LS_addr,
    input  logic [1:0]  LS_size,
    input  logic [31:0] LS_wdata,
    output logic        LS_done,
    output logic [31:0] LS_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic        wr_q, wr_d;
    logic        io_q, io_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic        ic_done_q, ic_done_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] ic_data_q, ic_data_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic        grant_ic, grant_ls, wr_stall;
    logic [1:0]  byte_idx;
    logic [31:0] captured;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        nbytes_d     = nbytes_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        wr_d         = wr_q;
        io_d         = io_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        wdata_d      = wdata_q;
        buf_d        = buf_q;
        ic_done_d    = ic_done_q;
        ls_done_d    = ls_done_q;
        ic_data_d    = ic_data_q;
        ls_rdata_d   = ls_rdata_q;
        grant_ic     = 1'b0;
        grant_ls     = 1'b0;
        wr_stall     = io_q && io_buffer_full;
        // With one cycle of RAM latency, the byte on mem_din is always the one for cnt-1.
        byte_idx     = cnt_q[1:0] - 2'd1;
        captured     = buf_q;
        captured[{byte_idx, 3'b000} +: 8] = mem_din;

        case (state_q)
            S_IDLE: begin
                if (rdy && !rollback) begin
                    if (IC_req && (!LS_req || last_grant_q)) grant_ic = 1'b1;
                    else if (LS_req)                         grant_ls = 1'b1;
                end
            end
            S_RD: begin
                if (rollback) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end else if (rdy) begin
                    if (cnt_q != 3'd0) buf_d = captured;
                    if (cnt_q == nbytes_q) begin
                        state_d = S_DONE;
                        cnt_d   = 3'd0;
                        if (owner_q) begin
                            ls_done_d  = 1'b1;
                            ls_rdata_d = captured;
                        end else begin
                            ic_done_d  = 1'b1;
                            ic_data_d  = captured;
                        end
                    end else begin
                        cnt_d  = cnt_q + 3'd1;
                        addr_d = addr_q + 32'd1;
                    end
                end
            end
            S_WR: begin
                if (rdy && !wr_stall) begin
                    addr_d  = addr_q + 32'd1;
                    dout_d  = wdata_q[15:8];
                    wdata_d = {8'h00, wdata_q[31:8]};
                    if (cnt_q == nbytes_q - 3'd1) begin
                        state_d   = S_DONE;
                        cnt_d     = 3'd0;
                        ls_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                if (rdy || (rollback && !wr_q)) begin
                    state_d   = S_IDLE;
                    ic_done_d = 1'b0;
                    ls_done_d = 1'b0;
                end
            end
        endcase

        if (grant_ic || grant_ls) begin
            owner_d      = grant_ls;
            last_grant_d = grant_ls;
            cnt_d        = 3'd0;
            buf_d        = 32'd0;
            if (grant_ls) begin
                addr_d   = LS_addr;
                nbytes_d = (LS_size == 2'd0) ? 3'd1 : (LS_size == 2'd1) ? 3'd2 : 3'd4;
                wdata_d  = LS_wdata;
                dout_d   = LS_wdata[7:0];
                wr_d     = LS_wr;
                io_d     = (LS_addr[17:16] == 2'b11);
                state_d  = LS_wr ? S_WR : S_RD;
            end else begin
                addr_d   = IC_addr;
                nbytes_d = 3'd4;
                wr_d     = 1'b0;
                io_d     = (IC_addr[17:16] == 2'b11);
                state_d  = S_RD;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            nbytes_q     <= 3'd0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            wr_q         <= 1'b0;
            io_q         <= 1'b0;
            addr_q       <= 32'd0;
            dout_q       <= 8'd0;
            wdata_q      <= 32'd0;
            buf_q        <= 32'd0;
            ic_done_q    <= 1'b0;
            ls_done_q    <= 1'b0;
            ic_data_q    <= 32'd0;
            ls_rdata_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            nbytes_q     <= nbytes_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            io_q         <= io_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            wdata_q      <= wdata_d;
            buf_q        <= buf_d;
            ic_done_q    <= ic_done_d;
            ls_done_q    <= ls_done_d;
            ic_data_q    <= ic_data_d;
            ls_rdata_q   <= ls_rdata_d;
        end
    end

    // While frozen mid-read, re-present the byte still owed so mem_din holds it when rdy returns.
    assign mem_a    = (state_q == S_RD && !rdy && cnt_q != 3'd0) ? addr_q - 32'd1 : addr_q;
    assign mem_wr   = (state_q == S_WR) && rdy && !wr_stall;
    assign mem_dout = dout_q;
    assign IC_done  = ic_done_q;
    assign IC_data  = ic_data_q;
    assign LS_done  = ls_done_q;
    assign LS_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 1-cycle-latency byte RAM model feeds mem_din.
// Inputs change and outputs are sampled on the falling edge; cycle 0 is the request cycle.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;
    logic        IC_req, IC_done;
    logic [31:0] IC_addr, IC_data;
    logic        LS_req, LS_wr, LS_done;
    logic [31:0] LS_addr, LS_wdata, LS_rdata;
    logic [1:0]  LS_size;

    logic [7:0]  ram [0:4095];
    int          n_checks = 0;
    int          n_fail   = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .IC_req(IC_req), .IC_addr(IC_addr), .IC_done(IC_done), .IC_data(IC_data),
        .LS_req(LS_req), .LS_wr(LS_wr), .LS_addr(LS_addr), .LS_size(LS_size),
        .LS_wdata(LS_wdata), .LS_done(LS_done), .LS_rdata(LS_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_din <= ram[mem_a[11:0]];

    task automatic do_reset;
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        IC_req = 1'b0; LS_req = 1'b0; LS_wr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        if ({mem_a, mem_dout, mem_wr} !== 41'd0) begin
            $display("FAIL reset_mem: got a=%h dout=%h wr=%b expected zeros", mem_a, mem_dout, mem_wr); n_fail++;
        end
        n_checks++;
        if ({IC_done, LS_done, IC_data, LS_rdata} !== 66'd0) begin
            $display("FAIL reset_outputs: got icd=%b lsd=%b icdata=%h lsdata=%h expected zeros",
                     IC_done, LS_done, IC_data, LS_rdata); n_fail++;
        end
        n_checks++;
        // Start a word write, then reset must abort it mid-flight.
        LS_req = 1'b1; LS_wr = 1'b1; LS_size = 2'd2; LS_addr = 32'h40; LS_wdata = 32'h12345678;
        @(negedge clk); #1;
        if (mem_wr !== 1'b1) begin
            $display("FAIL reset_pre_write: got mem_wr=%b expected 1", mem_wr); n_fail++;
        end
        n_checks++;
        rst = 1'b1;
        @(negedge clk); #1;
        if ({mem_a, mem_dout, mem_wr, LS_done} !== 42'd0) begin
            $display("FAIL reset_abort: got a=%h dout=%h wr=%b lsd=%b expected zeros", mem_a, mem_dout, mem_wr, LS_done); n_fail++;
        end
        n_checks++;
        LS_req = 1'b0; LS_wr = 1'b0; rst = 1'b0;
    endtask

    task automatic test_ic_read;
        do_reset();
        IC_addr = 32'h100; IC_req = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk); #1;
            if (c <= 4 && mem_a !== 32'h100 + 32'(c - 1)) begin
                $display("FAIL ic_read_addr c%0d: got %h expected %h", c, mem_a, 32'h100 + 32'(c - 1)); n_fail++;
            end
            if (c <= 4) n_checks++;
            if (mem_wr !== 1'b0) begin
                $display("FAIL ic_read_wr c%0d: got %b expected 0", c, mem_wr); n_fail++;
            end
            n_checks++;
            if (IC_done !== (c == 6)) begin
                $display("FAIL ic_read_done c%0d: got %b expected %b", c, IC_done, c == 6); n_fail++;
            end
            n_checks++;
            if (c == 6) begin
                if (IC_data !== 32'h44332211) begin
                    $display("FAIL ic_read_data: got %h expected 44332211", IC_data); n_fail++;
                end
                n_checks++;
                IC_req = 1'b0;
            end
        end
    endtask

    task automatic test_tie;
        do_reset();
        IC_addr = 32'h100; LS_addr = 32'h200; LS_size = 2'd1; LS_wr = 1'b0;
        IC_req = 1'b1; LS_req = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk); #1;
            if ((c == 1 || c == 13) && mem_a !== 32'h100) begin
                $display("FAIL tie_ic_grant c%0d: got mem_a=%h expected 00000100", c, mem_a); n_fail++;
            end
            if (c == 1 || c == 13) n_checks++;
            if (c == 8 && mem_a !== 32'h200) begin
                $display("FAIL tie_ls_grant c8: got mem_a=%h expected 00000200", mem_a); n_fail++;
            end
            if (c == 8) n_checks++;
            if (IC_done !== (c == 6) || LS_done !== (c == 11)) begin
                $display("FAIL tie_done c%0d: got ic=%b ls=%b expected ic=%b ls=%b", c, IC_done, LS_done, c == 6, c == 11); n_fail++;
            end
            n_checks++;
            if (c == 6) IC_req = 1'b0;
            if (c == 11) begin
                if (LS_rdata !== 32'h00005AA5) begin
                    $display("FAIL tie_ls_data: got %h expected 00005aa5", LS_rdata); n_fail++;
                end
                n_checks++;
                IC_req = 1'b1;
            end
        end
        IC_req = 1'b0; LS_req = 1'b0;
    endtask

    task automatic test_io_stall;
        do_reset();
        LS_addr = 32'h30000; LS_size = 2'd1; LS_wdata = 32'h0000BEEF; LS_wr = 1'b1; LS_req = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            io_buffer_full = (c <= 3);
            #1;
            if (mem_wr !== (c == 4 || c == 5)) begin
                $display("FAIL io_stall_wr c%0d: got %b expected %b", c, mem_wr, c == 4 || c == 5); n_fail++;
            end
            n_checks++;
            if (c == 4 && (mem_a !== 32'h30000 || mem_dout !== 8'hEF)) begin
                $display("FAIL io_stall_byte0: got a=%h d=%h expected 00030000/ef", mem_a, mem_dout); n_fail++;
            end
            if (c == 5 && (mem_a !== 32'h30001 || mem_dout !== 8'hBE)) begin
                $display("FAIL io_stall_byte1: got a=%h d=%h expected 00030001/be", mem_a, mem_dout); n_fail++;
            end
            if (c == 4 || c == 5) n_checks++;
            if (LS_done !== (c == 6)) begin
                $display("FAIL io_stall_done c%0d: got %b expected %b", c, LS_done, c == 6); n_fail++;
            end
            n_checks++;
            if (c == 6) begin LS_req = 1'b0; LS_wr = 1'b0; end
        end
        io_buffer_full = 1'b0;
    endtask

    task automatic test_rollback_read;
        do_reset();
        LS_addr = 32'h8; LS_size = 2'd0; LS_wr = 1'b0; LS_req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            rollback = (c == 2);
            #1;
            if ((c == 1 || c == 4) && mem_a !== 32'h8) begin
                $display("FAIL rb_read_addr c%0d: got %h expected 00000008", c, mem_a); n_fail++;
            end
            if (c == 1 || c == 4) n_checks++;
            if (c == 3 && (mem_a !== 32'h9 || LS_rdata !== 32'd0)) begin
                $display("FAIL rb_read_abort: got a=%h rdata=%h expected 00000009/00000000", mem_a, LS_rdata); n_fail++;
            end
            if (c == 3) n_checks++;
            if (LS_done !== (c == 6)) begin
                $display("FAIL rb_read_done c%0d: got %b expected %b", c, LS_done, c == 6); n_fail++;
            end
            n_checks++;
            if (c == 6) begin
                if (LS_rdata !== 32'h000000F0) begin
                    $display("FAIL rb_read_data: got %h expected 000000f0", LS_rdata); n_fail++;
                end
                n_checks++;
                LS_req = 1'b0;
            end
        end
    endtask

    task automatic test_rollback_write;
        logic [31:0] w;
        do_reset();
        w = 32'hDDCCBBAA;
        LS_addr = 32'h40; LS_size = 2'd2; LS_wdata = w; LS_wr = 1'b1; LS_req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            rollback = (c == 2);
            #1;
            if (c <= 4 && (mem_wr !== 1'b1 || mem_a !== 32'h40 + 32'(c - 1) || mem_dout !== w[8*(c-1) +: 8])) begin
                $display("FAIL rb_write_byte c%0d: got wr=%b a=%h d=%h expected 1/%h/%h",
                         c, mem_wr, mem_a, mem_dout, 32'h40 + 32'(c - 1), w[8*(c-1) +: 8]); n_fail++;
            end
            if (c <= 4) n_checks++;
            if (LS_done !== (c == 5)) begin
                $display("FAIL rb_write_done c%0d: got %b expected %b", c, LS_done, c == 5); n_fail++;
            end
            n_checks++;
            if (c == 5) begin LS_req = 1'b0; LS_wr = 1'b0; end
        end
    endtask

    task automatic test_rdy_freeze;
        do_reset();
        IC_addr = 32'h100; IC_req = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            rdy = !(c == 3 || c == 4);
            #1;
            if (mem_wr !== 1'b0) begin
                $display("FAIL freeze_wr c%0d: got %b expected 0", c, mem_wr); n_fail++;
            end
            n_checks++;
            if (IC_done !== (c == 8)) begin
                $display("FAIL freeze_done c%0d: got %b expected %b", c, IC_done, c == 8); n_fail++;
            end
            n_checks++;
            if (IC_data !== ((c == 8) ? 32'h44332211 : 32'd0) && c <= 8) begin
                $display("FAIL freeze_data c%0d: got %h expected %h", c, IC_data, (c == 8) ? 32'h44332211 : 32'd0); n_fail++;
            end
            if (c <= 8) n_checks++;
            if (c == 8) IC_req = 1'b0;
        end
        rdy = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
        ram[12'h200] = 8'hA5; ram[12'h201] = 8'h5A;
        ram[12'h008] = 8'hF0;
        IC_addr = 32'd0; LS_addr = 32'd0; LS_wdata = 32'd0; LS_size = 2'd0;
        test_reset();
        test_ic_read();
        test_tie();
        test_io_stall();
        test_rollback_read();
        test_rollback_write();
        test_rdy_freeze();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 rdy  input 1  global enable; low = freeze.
REQ-003 rollback  input 1  misprediction flush.
REQ-004 mem_din  input 8  RAM read byte; mem_dout output 8  RAM write byte; mem_a output 32  RAM byte address; mem_wr output 1  1 = write.
REQ-005 io_buffer_full  input 1  UART buffer full.
REQ-006 IC_req input 1; IC_addr input 32; IC_done output 1; IC_data output 32  icache word-fetch port.
REQ-007 LS_req input 1; LS_wr input 1; LS_addr input 32; LS_size input 2 (0 = byte, 1 = half, 2/3 = word); LS_wdata input 32; LS_done output 1; LS_rdata output 32  load/store port.

Function
REQ-008 Shares the single byte-wide RAM port between icache (IC) and load/store buffer (LS); one transaction at a time.
REQ-009 States: IDLE, RD, WR, DONE; byte counter cnt 3 bits; last_grant 1 bit (0 = IC, 1 = LS).
REQ-010 Grant only in IDLE when rdy=1 and rollback=0: a single requester wins; on a tie, the requester not equal to last_grant wins; last_grant updates on every grant.
REQ-011 At grant, latch addr, size (IC = word), wdata and requester; go to RD, or to WR if LS_wr=1.
REQ-012 Requesters hold req and operands stable until their done; the arbiter ignores operand changes after grant.
REQ-013 Read timing: the request is sampled at the end of cycle 0; mem_a = A+k in cycle k+1; byte k is captured from mem_din at the end of cycle k+2; mem_wr = 0 throughout.
REQ-014 An N-byte read asserts done and data in cycle N+2 (word: cycle 6), in state DONE.
REQ-015 Data assembly is little-endian: byte k goes to bits [8k+7:8k]; unread upper bytes are 0 (zero-extend).
REQ-016 Write timing: in cycle k+1, mem_wr = 1, mem_a = A+k, mem_dout = wdata[8k+7:8k]; LS_done is asserted in cycle N+1 (state DONE).
REQ-017 IO write stall: if addr[17:16] = 2'b11 and io_buffer_full = 1, hold mem_wr = 0 and do not advance cnt; resume when io_buffer_full = 0.
REQ-018 IC_done and LS_done are 1-cycle registered pulses, only in DONE, only to the owner; DONE always returns to IDLE next cycle, so there is at least 1 idle cycle between grants.
REQ-019 Rollback = 1 at an edge forces RD (any requester) or DONE-of-read to IDLE, with cnt = 0, done outputs 0 and mem_a unchanged; WR transactions (committed stores) continue unaffected.
REQ-020 rdy = 0 freezes state, cnt, data and done registers; mem_wr forced 0 that cycle; the byte is reissued after rdy returns.
REQ-021 Address arithmetic is 32-bit modulo; wrap-around at 0xFFFFFFFF is permitted and not flagged.
REQ-022 In IDLE and DONE, mem_wr = 0.

Reset
REQ-023 rst = 1 at an edge sets state = IDLE, cnt = 0, last_grant = 1, mem_a = 0, mem_dout = 0, mem_wr = 0, IC_done = 0, LS_done = 0, IC_data = 0, LS_rdata = 0, aborting any transaction including writes.
REQ-024 rst has priority over rdy and rollback.

Verification
REQ-025 IC_req, IC_addr = 0x100, RAM bytes 11,22,33,44 -> mem_a = 0x100..0x103 in cycles 1-4, IC_done = 1 in cycle 6 with IC_data = 0x44332211.
REQ-026 IC_req and LS_req raised together from reset -> IC granted first; LS granted at the first IDLE after IC_done; next tie -> IC.
REQ-027 LS write, size 1, addr 0x30000, wdata 0xBEEF, io_buffer_full = 1 for cycles 1-3 -> mem_wr = 0 in cycles 1-3; EF written in cycle 4, BE in cycle 5; LS_done in cycle 6.
REQ-028 LS byte read at addr 0x8 returning 0xF0, with rollback pulsed in cycle 2 -> IDLE in cycle 3, no LS_done; a new grant is possible in cycle 3.
REQ-029 LS word write in progress, rollback in cycle 2 -> all 4 bytes written, LS_done asserted in cycle 5.
REQ-030 rdy = 0 for 2 cycles during an IC read -> all registers held, mem_wr = 0, IC_done delayed by exactly 2 cycles with correct data.
